// File: rtl/birthday_entry.sv
// rtl/birthday_entry.sv - pushbutton entry of an MMDDYY BCD date
//
// Purpose: debounces two active-low keys and edits month, day and year one
// field at a time. The date drives the BCD bus of the seven-segment decoders.
//
// Ports:
//   MAX10_CLK1_50  in   1   system clock, rising edge
//   RESET_N        in   1   asynchronous active-low reset
//   KEY            in   2   raw keys, active-low; [0]=increment, [1]=advance/commit
//   BIRTHDAY       out  24  BCD date {M1,M0,D1,D0,Y1,Y0}
//   FIELD          out  2   edit cursor: 0=MM, 1=DD, 2=YY, 3=committed
//   VALID          out  1   high while committed
//   DONE           out  1   one-cycle pulse on entry to committed
module birthday_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic [23:0] RESET_DATE      = 24'h010100
) (
  input  logic        MAX10_CLK1_50,
  input  logic        RESET_N,
  input  logic [1:0]  KEY,
  output logic [23:0] BIRTHDAY,
  output logic [1:0]  FIELD,
  output logic        VALID,
  output logic        DONE
);

  // The counter only has to hold 0..DEBOUNCE_CYCLES-1: the level flips on the
  // edge where the count would reach DEBOUNCE_CYCLES.
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    EDIT_MM = 2'd0,
    EDIT_DD = 2'd1,
    EDIT_YY = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  logic [1:0] press;

  for (genvar g = 0; g < 2; g++) begin : g_key
    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        sync1   <= 1'b1;
        sync2   <= 1'b1;
        level   <= 1'b1;
        level_d <= 1'b1;
        cnt     <= '0;
      end else begin
        sync1   <= KEY[g];
        sync2   <= sync1;
        level_d <= level;
        if (sync2 == level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    // Falling debounced level only; releases produce nothing.
    assign press[g] = level_d & ~level;
  end

  logic inc_p;
  logic adv_p;
  assign inc_p = press[0];
  assign adv_p = press[1];

  // Increment a two-digit BCD field within [lo, hi], wrapping hi -> lo.
  // Anything that is not valid BCD or lies outside the range recovers to lo.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                         input logic [7:0] lo,
                                         input logic [7:0] hi);
    logic [3:0] tens;
    logic [3:0] units;
    logic [7:0] bin;
    tens  = v[7:4];
    units = v[3:0];
    bin   = {4'd0, tens} * 8'd10 + {4'd0, units};
    if (tens > 4'd9 || units > 4'd9 || bin < lo || bin >= hi)
      bcd_inc = {4'd0, lo[3:0]};
    else if (units == 4'd9)
      bcd_inc = {tens + 4'd1, 4'd0};
    else
      bcd_inc = {tens, units + 4'd1};
  endfunction

  state_t      state_q;
  state_t      state_n;
  logic [23:0] date_q;
  logic [23:0] date_n;
  logic        valid_q;
  logic        done_q;

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= EDIT_MM;
      date_q  <= RESET_DATE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      date_q  <= date_n;
      valid_q <= (state_n == COMMIT);
      done_q  <= (state_n == COMMIT) && (state_q != COMMIT);
    end
  end

  always_comb begin
    state_n = state_q;
    date_n  = date_q;
    // Advance has priority; a simultaneous increment is dropped.
    if (adv_p) begin
      unique case (state_q)
        EDIT_MM: state_n = EDIT_DD;
        EDIT_DD: state_n = EDIT_YY;
        EDIT_YY: state_n = COMMIT;
        COMMIT:  state_n = EDIT_MM;
      endcase
    end else if (inc_p) begin
      unique case (state_q)
        EDIT_MM: date_n[23:16] = bcd_inc(date_q[23:16], 8'd1, 8'd12);
        EDIT_DD: date_n[15:8]  = bcd_inc(date_q[15:8],  8'd1, 8'd31);
        EDIT_YY: date_n[7:0]   = bcd_inc(date_q[7:0],   8'd0, 8'd99);
        COMMIT:  date_n        = date_q;
      endcase
    end
  end

  assign BIRTHDAY = date_q;
  assign FIELD    = state_q;
  assign VALID    = valid_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_birthday_entry.sv
// tb/tb_birthday_entry.sv - randomized self-checking bench for birthday_entry
module tb_birthday_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  key = 2'b11;
  logic [23:0] birthday;
  logic [1:0]  field;
  logic        valid;
  logic        done;

  int checks = 0;
  int failures = 0;

  // Reference model: plain integers for the date and the cursor.
  int m = 1;
  int d = 1;
  int y = 0;
  int f = 0;

  birthday_entry #(
    .DEBOUNCE_CYCLES(4),
    .RESET_DATE(24'h010100)
  ) dut (
    .MAX10_CLK1_50(clk),
    .RESET_N(rst_n),
    .KEY(key),
    .BIRTHDAY(birthday),
    .FIELD(field),
    .VALID(valid),
    .DONE(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] to_bcd(input int mm, input int dd, input int yy);
    logic [23:0] r;
    r = {4'(mm / 10), 4'(mm % 10), 4'(dd / 10), 4'(dd % 10), 4'(yy / 10), 4'(yy % 10)};
    return r;
  endfunction

  task automatic model_step(input bit adv, input bit inc);
    if (adv) begin
      f = (f + 1) % 4;
    end else if (inc) begin
      case (f)
        0: m = (m == 12) ? 1 : m + 1;
        1: d = (d == 31) ? 1 : d + 1;
        2: y = (y + 1) % 100;
        default: ;
      endcase
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_bday"}, birthday, to_bcd(m, d, y));
    check({tag, "_field"}, 24'(field), 24'(f));
    check({tag, "_valid"}, 24'(valid), 24'(f == 3));
  endtask

  // Clean press: nothing may change for 6 cycles, the update lands on the 7th,
  // and holding longer must not repeat.
  task automatic press(input bit adv, input bit inc, input int hold);
    key = {~adv, ~inc};
    repeat (6) tick();
    check_state("early");
    tick();
    model_step(adv, inc);
    check_state("strobe");
    check("done_entry", 24'(done), 24'(adv && f == 3));
    tick();
    check("done_one", 24'(done), 24'(0));
    repeat (hold) tick();
    check_state("held");
    key = 2'b11;
    repeat (8) tick();
  endtask

  task automatic bouncy_inc();
    int n;
    n = $urandom_range(2, 4);
    for (int i = 0; i < n; i++) begin
      key[0] = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
      key[0] = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      check_state("bounce");
    end
    key[0] = 1'b0;
    repeat (14) tick();
    model_step(1'b0, 1'b1);
    check_state("bounce_settle");
    key = 2'b11;
    repeat (8) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key = 2'b11;
    repeat (2) tick();
    check("rst_bday", birthday, 24'h010100);
    check("rst_field", 24'(field), 24'(0));
    check("rst_valid", 24'(valid), 24'(0));
    check("rst_done", 24'(done), 24'(0));
    rst_n = 1'b1;
    m = 1; d = 1; y = 0; f = 0;
    repeat (2) tick();
  endtask

  initial begin
    do_reset();

    for (int i = 0; i < 11; i++) press(1'b0, 1'b1, 2);
    check("mm_12", birthday, 24'h120100);
    press(1'b0, 1'b1, 2);
    check("mm_wrap", birthday, 24'h010100);

    press(1'b1, 1'b0, 2);
    for (int i = 0; i < 30; i++) press(1'b0, 1'b1, 1);
    check("dd_31", birthday, 24'h013100);
    press(1'b0, 1'b1, 1);
    check("dd_wrap", birthday, 24'h010100);
    press(1'b1, 1'b0, 1);
    for (int i = 0; i < 9; i++) press(1'b0, 1'b1, 1);
    check("yy_09", birthday, 24'h010109);
    press(1'b0, 1'b1, 1);
    check("yy_carry", birthday, 24'h010110);

    do_reset();
    for (int i = 0; i < 4; i++) press(1'b0, 1'b1, 1);
    press(1'b1, 1'b0, 1);
    for (int i = 0; i < 17; i++) press(1'b0, 1'b1, 1);
    press(1'b1, 1'b0, 1);
    press(1'b1, 1'b0, 3);
    check("commit_bday", birthday, 24'h051800);
    check("commit_field", 24'(field), 24'(3));
    check("commit_valid", 24'(valid), 24'(1));
    press(1'b0, 1'b1, 3);
    check("commit_hold", birthday, 24'h051800);
    press(1'b1, 1'b0, 1);
    check("reedit_valid", 24'(valid), 24'(0));
    check("reedit_bday", birthday, 24'h051800);

    bouncy_inc();
    check("bounce_one", birthday, 24'h061800);
    press(1'b1, 1'b1, 2);
    check("both_field", 24'(field), 24'(1));
    check("both_bday", birthday, 24'h061800);

    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 11);
      if (op <= 6)       press(1'b0, 1'b1, $urandom_range(0, 6));
      else if (op <= 8)  press(1'b1, 1'b0, $urandom_range(0, 6));
      else if (op == 9)  press(1'b1, 1'b1, $urandom_range(0, 6));
      else if (f != 3)   bouncy_inc();
    end

    do_reset();
    for (int i = 0; i < 6; i++) press(1'b0, 1'b1, 0);
    press(1'b1, 1'b0, 0);
    for (int i = 0; i < 30; i++) press(1'b0, 1'b1, 0);
    press(1'b1, 1'b0, 0);
    for (int i = 0; i < 99; i++) press(1'b0, 1'b1, 0);
    check("pre_rst", birthday, 24'h073199);
    key = 2'b10;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_bday", birthday, 24'h010100);
    check("async_field", 24'(field), 24'(0));
    check("async_valid", 24'(valid), 24'(0));
    key = 2'b11;
    repeat (2) tick();
    rst_n = 1'b1;
    m = 1; d = 1; y = 0; f = 0;
    repeat (15) tick();
    check_state("no_stale_strobe");

    rst_n = 1'b0;
    key = 2'b10;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check_state("held_rst_early");
    tick();
    model_step(1'b0, 1'b1);
    check_state("held_rst_strobe");
    repeat (10) tick();
    check_state("held_rst_once");
    key = 2'b11;
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
